// File: rtl/decode_pkg.sv
// Shared definitions for the multi-lane decode stage.
// Holds opcodes, control-word bit positions, ALU select codes, branch types,
// the per-lane decode record and the ALU select helper used by decode_lane.
package decode_pkg;

    // Supported major opcodes (instr[6:0])
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Bit positions inside the 8-bit control word
    localparam int CTRL_REGWRITE  = 7;
    localparam int CTRL_ALUSRC    = 6;
    localparam int CTRL_MEMTOREG  = 5;
    localparam int CTRL_MEMRE     = 4;
    localparam int CTRL_MEMWR     = 3;
    localparam int CTRL_BYTEWORD  = 2;
    localparam int CTRL_ALUOP_LSB = 0;

    // aluop field encodings
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU select codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SLL = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1010;
    localparam logic [3:0] ALU_SRA = 4'b1011;
    localparam logic [3:0] ALU_OR  = 4'b1100;
    localparam logic [3:0] ALU_AND = 4'b1110;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLT  = 3'b011,
        BR_BGE  = 3'b100,
        BR_JAL  = 3'b101,
        BR_JALR = 3'b110
    } br_type_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [7:0]  ctrls;
        logic [3:0]  alu_sel;
        br_type_e    br_type;
        logic        illegal;
    } lane_dec_t;

    // aluop 10 defers to funct3; instr[5] distinguishes R-type SUB from ADDI.
    function automatic logic [3:0] alu_sel_f(input logic [1:0] aluop,
                                             input logic [2:0] funct3,
                                             input logic       bit30,
                                             input logic       bit5);
        logic [3:0] sel;
        sel = ALU_ADD;
        if (aluop == ALUOP_BR) begin
            sel = ALU_SUB;
        end else if (aluop != ALUOP_ADD) begin
            case (funct3)
                3'b000:  sel = (bit30 & bit5) ? ALU_SUB : ALU_ADD;
                3'b001:  sel = ALU_SLL;
                3'b100:  sel = ALU_XOR;
                3'b101:  sel = bit30 ? ALU_SRA : ALU_SRL;
                3'b110:  sel = ALU_OR;
                3'b111:  sel = ALU_AND;
                default: sel = ALU_ADD;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/decode_lane.sv
// Single-instruction combinational decoder (one lane of decode_stage).
// Latency 0 (pure combinational); no flow control of its own.
// Ports: instr_i / lane_valid_i in, dec_o (lane_dec_t) out. Invalid lanes give
// all-zero fields; unsupported opcodes on valid lanes give zeros plus illegal.
// Macro DECODE_BRANCH_EN: enables BEQ/BNE/BLT/BGE, JAL and JALR decode;
// without it those opcodes are illegal and br_type stays 0.
module decode_lane import decode_pkg::*; (
    input  logic [31:0] instr_i,
    input  logic        lane_valid_i,
    output lane_dec_t   dec_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_u  = {instr_i[31:12], 12'b0};

`ifdef DECODE_BRANCH_EN
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    assign imm_b = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_j = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
`endif

    lane_dec_t dec;
    logic      legal;

    always_comb begin
        dec   = '0;
        legal = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                dec.rd  = instr_i[11:7];
                dec.rs1 = instr_i[19:15];
                dec.rs2 = instr_i[24:20];
                dec.ctrls[CTRL_REGWRITE] = 1'b1;
                dec.ctrls[CTRL_ALUOP_LSB +: 2] = ALUOP_FUNCT;
            end
            OP_LOAD: begin
                dec.rd  = instr_i[11:7];
                dec.rs1 = instr_i[19:15];
                dec.imm = imm_i;
                dec.ctrls[CTRL_REGWRITE] = 1'b1;
                dec.ctrls[CTRL_ALUSRC]   = 1'b1;
                dec.ctrls[CTRL_MEMTOREG] = 1'b1;
                dec.ctrls[CTRL_MEMRE]    = 1'b1;
                dec.ctrls[CTRL_BYTEWORD] = (funct3 != 3'b000);
                dec.ctrls[CTRL_ALUOP_LSB +: 2] = ALUOP_ADD;
            end
            OP_IALU: begin
                dec.rd  = instr_i[11:7];
                dec.rs1 = instr_i[19:15];
                dec.imm = imm_i;
                dec.ctrls[CTRL_REGWRITE] = 1'b1;
                dec.ctrls[CTRL_ALUSRC]   = 1'b1;
                dec.ctrls[CTRL_BYTEWORD] = 1'b1;
                dec.ctrls[CTRL_ALUOP_LSB +: 2] = ALUOP_FUNCT;
            end
            OP_STORE: begin
                dec.rs1 = instr_i[19:15];
                dec.rs2 = instr_i[24:20];
                dec.imm = imm_s;
                dec.ctrls[CTRL_ALUSRC]   = 1'b1;
                dec.ctrls[CTRL_MEMWR]    = 1'b1;
                dec.ctrls[CTRL_BYTEWORD] = (funct3 != 3'b000);
                dec.ctrls[CTRL_ALUOP_LSB +: 2] = ALUOP_FUNCT;
            end
            OP_LUI: begin
                dec.rd  = instr_i[11:7];
                dec.imm = imm_u;
                dec.ctrls[CTRL_REGWRITE] = 1'b1;
                dec.ctrls[CTRL_ALUSRC]   = 1'b1;
                dec.ctrls[CTRL_BYTEWORD] = 1'b1;
                dec.ctrls[CTRL_ALUOP_LSB +: 2] = ALUOP_ADD;
            end
            OP_BRANCH: begin
`ifdef DECODE_BRANCH_EN
                dec.rs1 = instr_i[19:15];
                dec.rs2 = instr_i[24:20];
                dec.imm = imm_b;
                dec.ctrls[CTRL_ALUOP_LSB +: 2] = ALUOP_BR;
                case (funct3)
                    3'b000:  dec.br_type = BR_BEQ;
                    3'b001:  dec.br_type = BR_BNE;
                    3'b100:  dec.br_type = BR_BLT;
                    3'b101:  dec.br_type = BR_BGE;
                    default: legal = 1'b0;
                endcase
`else
                legal = 1'b0;
`endif
            end
            OP_JAL: begin
`ifdef DECODE_BRANCH_EN
                dec.rd      = instr_i[11:7];
                dec.imm     = imm_j;
                dec.br_type = BR_JAL;
                dec.ctrls[CTRL_REGWRITE] = 1'b1;
                dec.ctrls[CTRL_BYTEWORD] = 1'b1;
                dec.ctrls[CTRL_ALUOP_LSB +: 2] = ALUOP_ADD;
`else
                legal = 1'b0;
`endif
            end
            OP_JALR: begin
`ifdef DECODE_BRANCH_EN
                dec.rd      = instr_i[11:7];
                dec.rs1     = instr_i[19:15];
                dec.imm     = imm_i;
                dec.br_type = BR_JALR;
                dec.ctrls[CTRL_REGWRITE] = 1'b1;
                dec.ctrls[CTRL_ALUSRC]   = 1'b1;
                dec.ctrls[CTRL_BYTEWORD] = 1'b1;
                dec.ctrls[CTRL_ALUOP_LSB +: 2] = ALUOP_ADD;
`else
                legal = 1'b0;
`endif
            end
            default: legal = 1'b0;
        endcase

        dec.alu_sel = alu_sel_f(dec.ctrls[CTRL_ALUOP_LSB +: 2], funct3,
                                instr_i[30], instr_i[5]);

        // Empty lanes and unsupported opcodes carry no decode information.
        if (!lane_valid_i || !legal) begin
            dec         = '0;
            dec.illegal = lane_valid_i & ~legal;
        end
    end

    assign dec_o = dec;

endmodule

// File: rtl/decode_stage.sv
// Multi-lane decode stage: decodes N lanes per bundle into register indices,
// immediate, control word, ALU select and branch type.
// Latency 1 cycle; in_ready is registered and drops only while both the output
// register and the skid register are full; flush empties both at the next edge.
// Ports: clk/rst (sync, active-high), flush, in_valid/in_ready/in_instr/
// in_lane_valid/in_pc on the fetch side; out_valid/out_ready plus per-lane
// out_* fields on the register-read side. Branch decode is enabled by the
// DECODE_BRANCH_EN macro (inside decode_lane); ports are identical either way.
module decode_stage import decode_pkg::*; #(
    parameter int INSTR_WIDTH       = 32,
    parameter int N_INSTR_PER_CYCLE = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [N_INSTR_PER_CYCLE*INSTR_WIDTH-1:0] in_instr,
    input  logic [N_INSTR_PER_CYCLE-1:0]          in_lane_valid,
    input  logic [31:0]                           in_pc,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [N_INSTR_PER_CYCLE-1:0]          out_lane_valid,
    output logic [N_INSTR_PER_CYCLE*32-1:0]       out_pc,
    output logic [N_INSTR_PER_CYCLE*5-1:0]        out_rd,
    output logic [N_INSTR_PER_CYCLE*5-1:0]        out_rs1,
    output logic [N_INSTR_PER_CYCLE*5-1:0]        out_rs2,
    output logic [N_INSTR_PER_CYCLE*32-1:0]       out_imm,
    output logic [N_INSTR_PER_CYCLE*8-1:0]        out_ctrls,
    output logic [N_INSTR_PER_CYCLE*4-1:0]        out_alu_sel,
    output logic [N_INSTR_PER_CYCLE*3-1:0]        out_br_type,
    output logic [N_INSTR_PER_CYCLE-1:0]          out_illegal
);

    localparam int N = N_INSTR_PER_CYCLE;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,   // OR and SK free
        ST_ONE   = 2'b01,   // OR full
        ST_TWO   = 2'b10    // OR and SK full
    } state_e;

    // Incoming bundle, decoded combinationally before registering
    lane_dec_t [N-1:0]   in_dec;
    logic [N*32-1:0]     in_pc_lanes;

    // Output register (OR) and skid register (SK)
    state_e              state_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [N-1:0]        or_lv_q;
    logic [N*32-1:0]     or_pc_q;
    lane_dec_t [N-1:0]   or_dec_q;
    logic [N-1:0]        sk_lv_q;
    logic [N*32-1:0]     sk_pc_q;
    lane_dec_t [N-1:0]   sk_dec_q;

    logic                accept;

    for (genvar g = 0; g < N; g++) begin : g_lane
        decode_lane u_lane (
            .instr_i      (in_instr[g*INSTR_WIDTH +: INSTR_WIDTH]),
            .lane_valid_i (in_lane_valid[g]),
            .dec_o        (in_dec[g])
        );
        assign in_pc_lanes[g*32 +: 32] = in_pc + 32'(4 * g);

        assign out_rd[g*5 +: 5]      = or_dec_q[g].rd;
        assign out_rs1[g*5 +: 5]     = or_dec_q[g].rs1;
        assign out_rs2[g*5 +: 5]     = or_dec_q[g].rs2;
        assign out_imm[g*32 +: 32]   = or_dec_q[g].imm;
        assign out_ctrls[g*8 +: 8]   = or_dec_q[g].ctrls;
        assign out_alu_sel[g*4 +: 4] = or_dec_q[g].alu_sel;
        assign out_br_type[g*3 +: 3] = or_dec_q[g].br_type;
        assign out_illegal[g]        = or_dec_q[g].illegal;
    end

    // in_ready_q tracks (state != TWO) one edge ahead; masking with rst keeps
    // it low while reset is held and lets it rise the first cycle after.
    assign in_ready       = in_ready_q & ~rst;
    assign accept         = in_valid & in_ready & ~flush;
    assign out_valid      = out_valid_q;
    assign out_lane_valid = or_lv_q;
    assign out_pc         = or_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            or_lv_q     <= '0;
            or_pc_q     <= '0;
            or_dec_q    <= '0;
            sk_lv_q     <= '0;
            sk_pc_q     <= '0;
            sk_dec_q    <= '0;
        end else if (flush) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        or_lv_q     <= in_lane_valid;
                        or_pc_q     <= in_pc_lanes;
                        or_dec_q    <= in_dec;
                        state_q     <= ST_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && out_ready) begin
                        or_lv_q  <= in_lane_valid;
                        or_pc_q  <= in_pc_lanes;
                        or_dec_q <= in_dec;
                    end else if (accept) begin
                        // Consumer stalled: park the new bundle behind OR.
                        sk_lv_q    <= in_lane_valid;
                        sk_pc_q    <= in_pc_lanes;
                        sk_dec_q   <= in_dec;
                        state_q    <= ST_TWO;
                        in_ready_q <= 1'b0;
                    end else if (out_ready) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (out_ready) begin
                        or_lv_q    <= sk_lv_q;
                        or_pc_q    <= sk_pc_q;
                        or_dec_q   <= sk_dec_q;
                        state_q    <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    localparam int N = 2;
    localparam int W = N * 96;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [7:0]  ctl;
        logic [3:0]  sel;
        logic [2:0]  br;
        logic        ill;
    } exp_lane_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [N*32-1:0] in_instr = '0;
    logic [N-1:0]    in_lane_valid = '0;
    logic [31:0]     in_pc = '0;
    logic            in_ready;
    logic            out_valid;
    logic [N-1:0]    out_lane_valid;
    logic [N*32-1:0] out_pc;
    logic [N*5-1:0]  out_rd;
    logic [N*5-1:0]  out_rs1;
    logic [N*5-1:0]  out_rs2;
    logic [N*32-1:0] out_imm;
    logic [N*8-1:0]  out_ctrls;
    logic [N*4-1:0]  out_alu_sel;
    logic [N*3-1:0]  out_br_type;
    logic [N-1:0]    out_illegal;

    logic [W-1:0]    got;
    logic [W-1:0]    exp_q[$];
    logic [W-1:0]    pend;
    logic            last_acc;
    int              checks = 0;
    int              errors = 0;

    decode_stage #(.INSTR_WIDTH(32), .N_INSTR_PER_CYCLE(N)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_lane_valid(in_lane_valid), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_valid(out_lane_valid), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_ctrls(out_ctrls), .out_alu_sel(out_alu_sel),
        .out_br_type(out_br_type), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    assign got = {out_lane_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
                  out_ctrls, out_alu_sel, out_br_type, out_illegal};

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference decode: classify by format, then fill fields the format uses.
    function automatic exp_lane_t ref_lane(input logic [31:0] ins, input logic v);
        exp_lane_t  e;
        byte        fmt;
        logic [2:0] f3;
        logic [3:0] sel_tab [8];
        e       = '0;
        fmt     = "?";
        f3      = ins[14:12];
        sel_tab = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h8, 4'hA, 4'hC, 4'hE};
        if (!v) return e;
        case (ins[6:0])
            7'h33: begin fmt = "R"; e.ctl = 8'h82; end
            7'h03: begin fmt = "I"; e.ctl = (f3 != 0) ? 8'hF4 : 8'hF0; end
            7'h13: begin fmt = "I"; e.ctl = 8'hC6; end
            7'h23: begin fmt = "S"; e.ctl = (f3 != 0) ? 8'h4E : 8'h4A; end
            7'h37: begin fmt = "U"; e.ctl = 8'hC4; end
`ifdef DECODE_BRANCH_EN
            7'h63: begin
                fmt = "B"; e.ctl = 8'h01;
                case (f3)
                    3'd0: e.br = 3'd1;
                    3'd1: e.br = 3'd2;
                    3'd4: e.br = 3'd3;
                    3'd5: e.br = 3'd4;
                    default: fmt = "?";
                endcase
            end
            7'h6F: begin fmt = "J"; e.ctl = 8'h84; e.br = 3'd5; end
            7'h67: begin fmt = "I"; e.ctl = 8'hC4; e.br = 3'd6; end
`endif
            default: fmt = "?";
        endcase
        if (fmt == "?") begin
            e     = '0;
            e.ill = 1'b1;
            return e;
        end
        if (fmt inside {"R", "I", "U", "J"}) e.rd  = ins[11:7];
        if (fmt inside {"R", "I", "S", "B"}) e.rs1 = ins[19:15];
        if (fmt inside {"R", "S", "B"})      e.rs2 = ins[24:20];
        case (fmt)
            "I": e.imm = {{20{ins[31]}}, ins[31:20]};
            "S": e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            "B": e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            "J": e.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            "U": e.imm = {ins[31:12], 12'h000};
            default: e.imm = '0;
        endcase
        case (e.ctl[1:0])
            2'b00: e.sel = 4'h0;
            2'b01: e.sel = 4'h1;
            default: begin
                e.sel = sel_tab[f3];
                if (f3 == 3'd0 && ins[30] && ins[5]) e.sel = 4'h1;
                if (f3 == 3'd5 && ins[30])           e.sel = 4'hB;
            end
        endcase
        return e;
    endfunction

    function automatic logic [W-1:0] exp_bundle(input logic [N*32-1:0] ins,
                                                input logic [N-1:0] lv,
                                                input logic [31:0] pc);
        logic [N*32-1:0] p, im;
        logic [N*5-1:0]  rd, r1, r2;
        logic [N*8-1:0]  c;
        logic [N*4-1:0]  s;
        logic [N*3-1:0]  b;
        logic [N-1:0]    il;
        exp_lane_t       e;
        for (int i = 0; i < N; i++) begin
            e = ref_lane(ins[i*32 +: 32], lv[i]);
            p[i*32 +: 32]  = pc + 32'(4 * i);
            rd[i*5 +: 5]   = e.rd;
            r1[i*5 +: 5]   = e.rs1;
            r2[i*5 +: 5]   = e.rs2;
            im[i*32 +: 32] = e.imm;
            c[i*8 +: 8]    = e.ctl;
            s[i*4 +: 4]    = e.sel;
            b[i*3 +: 3]    = e.br;
            il[i]          = e.ill;
        end
        return {lv, p, rd, r1, r2, im, c, s, b, il};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10];
        logic [31:0] r;
        ops = '{7'h33, 7'h03, 7'h13, 7'h23, 7'h37, 7'h63, 7'h6F, 7'h67, 7'h7F, 7'h00};
        r = $urandom();
        r[6:0] = ops[$urandom_range(0, 9)];
        return r;
    endfunction

    // One cycle of stimulus, entered and left at #1 after a rising edge.
    task automatic drive_cycle(input logic v, input logic [N*32-1:0] ins,
                               input logic [N-1:0] lv, input logic [31:0] pc,
                               input logic ordy, input logic fl);
        in_valid = v; in_instr = ins; in_lane_valid = lv; in_pc = pc;
        out_ready = ordy; flush = fl;
        @(negedge clk);
        last_acc = in_valid && in_ready && !flush;
        if (last_acc) pend = exp_bundle(ins, lv, pc);
        @(posedge clk);
        #1;
        if (fl) exp_q.delete();
        if (last_acc) exp_q.push_back(pend);
    endtask

    task automatic offer(input logic [N*32-1:0] ins, input logic [N-1:0] lv, input logic [31:0] pc);
        int tries = 0;
        do begin
            drive_cycle(1'b1, ins, lv, pc, 1'b1, 1'b0);
            tries++;
        end while (!last_acc && tries < 8);
        chk("offer_accepted", W'(last_acc), W'(1));
    endtask

    // Monitor: exp_q always mirrors the bundles the DUT currently holds.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("in_ready", W'(in_ready), W'(exp_q.size() != 2));
                chk("out_valid", W'(out_valid), W'(exp_q.size() != 0));
                if (out_valid && exp_q.size() != 0) begin
                    chk("bundle", got, exp_q[0]);
                    if (out_ready && !flush) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N*32-1:0] ins;
        logic [31:0]     lvr;
        // Reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(0));
        chk("rst_data", got, W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ADDI x1,x0,10 ; ADD x3,x1,x2 with 1-cycle latency
        drive_cycle(1'b1, {32'h002081B3, 32'h00A00093}, 2'b11, 32'h1000, 1'b0, 1'b0);
        chk("t1_valid", W'(out_valid), W'(1));
        chk("t1_l0_rd", W'(out_rd[4:0]), W'(1));
        chk("t1_l0_imm", W'(out_imm[31:0]), W'(10));
        chk("t1_l0_ctrls", W'(out_ctrls[7:0]), W'(8'hC6));
        chk("t1_l0_alu", W'(out_alu_sel[3:0]), W'(0));
        chk("t1_l1_rd", W'(out_rd[9:5]), W'(3));
        chk("t1_l1_ctrls", W'(out_ctrls[15:8]), W'(8'h82));
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // Back-pressure: A to OR, B to SK, C blocked
        drive_cycle(1'b1, {32'h00C12403, 32'h407302B3}, 2'b11, 32'h2000, 1'b0, 1'b0);
        drive_cycle(1'b1, {32'h00208023, 32'h4030D093}, 2'b11, 32'h2008, 1'b0, 1'b0);
        chk("bp_in_ready_two", W'(in_ready), W'(0));
        drive_cycle(1'b1, {32'h0FF36313, 32'hABCDE2B7}, 2'b11, 32'h2010, 1'b0, 1'b0);
        chk("bp_c_blocked", W'(last_acc), W'(0));
        offer({32'h0FF36313, 32'hABCDE2B7}, 2'b11, 32'h2010);
        repeat (3) drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // Lane mask: lane1 empty even with garbage instruction
        drive_cycle(1'b1, {32'hFFFFFFFF, 32'h123450B7}, 2'b01, 32'h3000, 1'b1, 1'b0);
        chk("mask_illegal", W'(out_illegal), W'(0));
        chk("mask_l1_imm", W'(out_imm[63:32]), W'(0));
        chk("mask_l1_ctrls", W'(out_ctrls[15:8]), W'(0));
        chk("mask_l0_imm", W'(out_imm[31:0]), W'(32'h12345000));

        // Unsupported opcode in lane0
        drive_cycle(1'b1, {32'h0020A223, 32'h0000007F}, 2'b11, 32'h4000, 1'b1, 1'b0);
        chk("ill_flags", W'(out_illegal), W'(2'b01));
        chk("ill_l0_ctrls", W'(out_ctrls[7:0]), W'(0));
        chk("ill_l1_ctrls", W'(out_ctrls[15:8]), W'(8'h4E));
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // Flush while both registers are full, with a bundle offered
        drive_cycle(1'b1, {32'h00000013, 32'h00100093}, 2'b11, 32'h5000, 1'b0, 1'b0);
        drive_cycle(1'b1, {32'h00000013, 32'h00200093}, 2'b11, 32'h5008, 1'b0, 1'b0);
        drive_cycle(1'b1, {32'h00000013, 32'h00300093}, 2'b11, 32'h5010, 1'b0, 1'b1);
        chk("flush_out_valid", W'(out_valid), W'(0));
        chk("flush_in_ready", W'(in_ready), W'(1));
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
        chk("flush_dropped", W'(out_valid), W'(0));

        // BEQ x0,x0,-4
        drive_cycle(1'b1, {32'h00000013, 32'hFE000EE3}, 2'b11, 32'h6000, 1'b1, 1'b0);
`ifdef DECODE_BRANCH_EN
        chk("beq_br", W'(out_br_type[2:0]), W'(3'b001));
        chk("beq_imm", W'(out_imm[31:0]), W'(32'hFFFFFFFC));
        chk("beq_illegal", W'(out_illegal[0]), W'(0));
`else
        chk("beq_illegal", W'(out_illegal[0]), W'(1));
        chk("beq_br", W'(out_br_type[2:0]), W'(0));
`endif
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // Randomized traffic with random back-pressure and rare flushes
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) ins[i*32 +: 32] = rand_instr();
            lvr = $urandom();
            drive_cycle($urandom_range(0, 3) != 0, ins, lvr[N-1:0], $urandom(),
                        $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        end
        repeat (4) drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
        chk("drain_empty", W'(exp_q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
